// File: rtl/fc_state_tx.sv
// fc_state_tx: Fibre Channel port transmit word selector (primitive sequences / frames / fill IDLEs).
// Latency: 1 cycle from state and accepted word to data/datak; in_ready is combinational.
// Backpressure: in_ready holds off SOF until MIN_IDLES IDLEs follow an EOF; it accepts every word mid-frame and while draining.
//
// Ports:
//   clk, reset_n                 word clock, async active-low reset (release synchronised by two flops)
//   state                        current FC_Port state from the receive state machine
//   in_data/in_datak             framer word + K flags (byte 0 sent first)
//   in_valid/in_sop/in_eop       word qualifiers; in_ready = accept
//   data/datak                   registered word to the transceiver
//   underrun/abort               one-cycle event pulses
//   frames_tx/frames_aborted     present only when FC_STATE_TX_STATS_EN is defined

package fc;
  typedef enum logic [3:0] {
    STATE_AC  = 4'd0,
    STATE_LR1 = 4'd1,
    STATE_LR2 = 4'd2,
    STATE_LR3 = 4'd3,
    STATE_LF1 = 4'd4,
    STATE_LF2 = 4'd5,
    STATE_OL1 = 4'd6,
    STATE_OL2 = 4'd7,
    STATE_OL3 = 4'd8
  } state_t;
endpackage

module fc_state_tx #(
  parameter int MIN_IDLES = 6
) (
  input  logic        clk,
  input  logic        reset_n,
  input  fc::state_t  state,
  input  logic [31:0] in_data,
  input  logic [3:0]  in_datak,
  input  logic        in_valid,
  input  logic        in_sop,
  input  logic        in_eop,
  output logic        in_ready,
  output logic [31:0] data,
  output logic [3:0]  datak,
  output logic        underrun,
  output logic        abort
`ifdef FC_STATE_TX_STATS_EN
  ,
  output logic [31:0] frames_tx,
  output logic [15:0] frames_aborted
`endif
);

  // Ordered sets, byte 0 in bits [7:0].
  localparam logic [31:0] IDLE_W = 32'hB5B595BC;
  localparam logic [31:0] OLS_W  = 32'h558A35BC;
  localparam logic [31:0] NOS_W  = 32'h45BF55BC;
  localparam logic [31:0] LR_W   = 32'h49BF49BC;
  localparam logic [31:0] LRR_W  = 32'h49BF35BC;
  localparam logic [3:0]  K_OS   = 4'b0001;

  localparam int GW = (MIN_IDLES < 1) ? 1 : $clog2(MIN_IDLES + 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(MIN_IDLES);

  typedef enum logic [1:0] {
    M_IDLE  = 2'd0,
    M_FRAME = 2'd1,
    M_DRAIN = 2'd2
  } mode_t;

  function automatic logic [31:0] seq_word(input fc::state_t s);
    case (s)
      fc::STATE_LR1: seq_word = LR_W;
      fc::STATE_LR2: seq_word = LRR_W;
      fc::STATE_LR3: seq_word = IDLE_W;
      fc::STATE_LF1: seq_word = NOS_W;
      fc::STATE_LF2: seq_word = OLS_W;
      fc::STATE_OL1: seq_word = OLS_W;
      fc::STATE_OL2: seq_word = LR_W;
      fc::STATE_OL3: seq_word = NOS_W;
      fc::STATE_AC:  seq_word = IDLE_W;
      default:       seq_word = OLS_W;  // undefined encodings
    endcase
  endfunction

  // Reset release synchroniser: assertion is immediate, release waits two clocks.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  mode_t          r_mode;
  logic [GW-1:0]  r_gap;
  logic [31:0]    r_data;
  logic [3:0]     r_datak;
  logic           r_underrun;
  logic           r_abort;

  logic           w_ready;
  logic           w_in_ac;
  logic           w_gap_ok;
  logic [GW-1:0]  w_gap_inc;
  logic [31:0]    w_seq;
  logic           w_seq_is_idle;
  logic           w_sof_take;
  logic           w_frame_word;
  logic           w_abort_ev;

  assign w_in_ac       = (state == fc::STATE_AC);
  assign w_gap_ok      = (r_gap >= GAP_MAX);
  assign w_gap_inc     = (r_gap >= GAP_MAX) ? GAP_MAX : r_gap + 1'b1;
  assign w_seq         = seq_word(state);
  assign w_seq_is_idle = (w_seq == IDLE_W);

  // Outside a frame, a stray non-SOF word is always swallowed; only SOF waits on the gap.
  always_comb begin
    w_ready = 1'b0;
    if (w_rst_n) begin
      case (r_mode)
        M_DRAIN: w_ready = 1'b1;
        M_FRAME: w_ready = w_in_ac;
        default: w_ready = w_in_ac && (w_gap_ok || (in_valid && !in_sop));
      endcase
    end
  end

  assign in_ready     = w_ready;
  assign w_sof_take   = (r_mode == M_IDLE) && w_in_ac && in_valid && in_sop && w_ready;
  assign w_frame_word = (r_mode == M_FRAME) && w_in_ac && in_valid;
  assign w_abort_ev   = (r_mode == M_FRAME) && !w_in_ac;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_mode     <= M_IDLE;
      r_gap      <= GAP_MAX;
      r_data     <= OLS_W;
      r_datak    <= K_OS;
      r_underrun <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      r_abort    <= 1'b0;
      r_data     <= w_seq;
      r_datak    <= K_OS;
      case (r_mode)
        M_FRAME: begin
          if (w_abort_ev) begin
            // Frame cut on the wire: the port sequence takes over next cycle,
            // the rest of the frame is swallowed and the gap restarts.
            r_abort <= 1'b1;
            r_mode  <= M_DRAIN;
            r_gap   <= '0;
          end else if (w_frame_word) begin
            r_data  <= in_data;
            r_datak <= in_datak;
            if (in_eop) begin
              r_mode <= M_IDLE;
              r_gap  <= '0;
            end
          end else begin
            r_data     <= IDLE_W;
            r_underrun <= 1'b1;
          end
        end
        M_DRAIN: begin
          // Returning to AC does not reopen the frame; only the EOF word ends the drain.
          if (in_valid && in_eop) r_mode <= M_IDLE;
          if (w_seq_is_idle) r_gap <= w_gap_inc;
        end
        default: begin
          if (w_sof_take) begin
            r_data  <= in_data;
            r_datak <= in_datak;
            if (in_eop) r_gap  <= '0;  // single-word frame
            else        r_mode <= M_FRAME;
          end else if (w_seq_is_idle) begin
            r_gap <= w_gap_inc;
          end
        end
      endcase
    end
  end

  assign data     = r_data;
  assign datak    = r_datak;
  assign underrun = r_underrun;
  assign abort    = r_abort;

`ifdef FC_STATE_TX_STATS_EN
  logic [31:0] r_frames_tx;
  logic [15:0] r_frames_aborted;
  logic        w_eof_out;

  assign w_eof_out = (w_frame_word || w_sof_take) && in_eop;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_frames_tx      <= 32'd0;
      r_frames_aborted <= 16'd0;
    end else begin
      if (w_eof_out)  r_frames_tx      <= r_frames_tx + 32'd1;
      if (w_abort_ev) r_frames_aborted <= r_frames_aborted + 16'd1;
    end
  end

  assign frames_tx      = r_frames_tx;
  assign frames_aborted = r_frames_aborted;
`else
  // Statistics option off: no counters are built.
`endif

endmodule
